// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, condition-code layout and arbiter buffer states
package alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;
  typedef enum logic {EMPTY, FULL} buf_state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels plus the registered response channel
interface alu_arbiter_if #(parameter int WIDTH = 64);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic rsp_overflow;
  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );
  modport slave (
    input req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/alu.sv
// ALU: combinational add/sub/and/xor with signed overflow for add/sub
module ALU
  import alu_pkg::*;
#(parameter int WIDTH = 64) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  always_comb begin
    result = operation == ALU_ADD ? a + b :
             operation == ALU_SUB ? a - b :
             operation == ALU_AND ? a & b : a ^ b;
    overflow = operation == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]) :
               operation == ALU_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]) :
               1'b0;
  end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; ptr flips to the loser after every grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic ptr;
  always_comb gnt = !en ? 2'b00 : req == 2'b11 ? (ptr ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with a one-entry result buffer;
// define ALU_ARB_CC_EN to keep Y86 condition codes from requester-0 results
module alu_arbiter
  import alu_pkg::*;
#(parameter int WIDTH = 64) (
  input  logic               clk,
  input  logic               rst,
  alu_arbiter_if.slave       bus,
  output logic [2:0]         cc
);
  buf_state_e state_q, state_d;
  logic [1:0] gnt;
  logic out_free, sel, alu_ovf;
  logic [1:0] alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  assign out_free = !rst && (!bus.rsp_valid || bus.rsp_ready);
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(bus.req_valid), .en(out_free), .gnt(gnt));
  assign bus.req_ready = gnt;
  assign sel = gnt[1];
  assign alu_a = sel ? bus.req1_a : bus.req0_a;
  assign alu_b = sel ? bus.req1_b : bus.req0_b;
  assign alu_op = sel ? bus.req1_op : bus.req0_op;
  ALU #(.WIDTH(WIDTH)) u_alu (.a(alu_a), .b(alu_b), .operation(alu_op), .result(alu_res), .overflow(alu_ovf));
  always_comb state_d = (|gnt) ? FULL : bus.rsp_ready ? EMPTY : state_q;
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  end
  assign bus.rsp_valid = state_q == FULL;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_id <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_overflow <= 1'b0;
    end else if (|gnt) begin
      bus.rsp_id <= sel;
      bus.rsp_result <= alu_res;
      bus.rsp_overflow <= alu_ovf;
    end
  end
`ifdef ALU_ARB_CC_EN
  logic [2:0] cc_q;
  always_ff @(posedge clk) begin
    if (rst) cc_q <= CC_RESET;
    else if (gnt[0]) begin
      cc_q[CC_ZF] <= alu_res == '0;
      cc_q[CC_SF] <= alu_res[WIDTH-1];
      cc_q[CC_OF] <= alu_ovf;
    end
  end
  assign cc = cc_q;
`else
  assign cc = CC_RESET;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, buffering, overflow and condition codes
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] cc;
  int n_checks = 0;
  int n_fail = 0;
  alu_arbiter_if #(.WIDTH(64)) bus();
  alu_arbiter #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus), .cc(cc));
  always #5 clk = ~clk;
  function automatic logic [2:0] exp_cc(input logic [2:0] v);
`ifdef ALU_ARB_CC_EN
    return v;
`else
    return 3'b100 | (v & 3'b000);
`endif
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rsp(input string tag, input logic v, input logic id, input logic [63:0] r, input logic o);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'(v));
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
    chk({tag, "_result"}, bus.rsp_result, r);
    chk({tag, "_ovf"}, 64'(bus.rsp_overflow), 64'(o));
  endtask
  task automatic set0(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask
  task automatic set1(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    set0(0, 0, 2'b00);
    set1(0, 0, 2'b00);
    #1;
    chk("ready_in_reset", 64'(bus.req_ready), 64'(2'b00));
    step();
    step();
    chk_rsp("reset", 1'b0, 1'b0, 64'd0, 1'b0);
    chk("reset_cc", 64'(cc), 64'(3'b100));
    rst = 1'b0;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    set0(-64'sd5, 64'd107, 2'b00);
    #1;
    chk("add_ready", 64'(bus.req_ready), 64'(2'b01));
    step();
    bus.req_valid = 2'b00;
    chk_rsp("add", 1'b1, 1'b0, 64'd102, 1'b0);
    chk("add_cc", 64'(cc), 64'(exp_cc(3'b000)));
    step();
    chk("pop_empty", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    set0(64'hF0, 64'h0F, 2'b11);
    set1(64'hFF, 64'h0F, 2'b10);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", 64'(bus.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      step();
      chk_rsp("rr", 1'b1, 1'(i % 2), (i % 2 == 0) ? 64'hFF : 64'h0F, 1'b0);
    end
    bus.req_valid = 2'b00;
    chk("rr_cc", 64'(cc), 64'(exp_cc(3'b000)));
    step();
    chk("rr_drain", 64'(bus.rsp_valid), 64'd0);
    bus.req_valid = 2'b01;
    set0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
    step();
    chk_rsp("ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b1);
    chk("ovf_cc", 64'(cc), 64'(exp_cc(3'b011)));
    set0(64'd5, 64'd5, 2'b01);
    step();
    chk_rsp("zero", 1'b1, 1'b0, 64'd0, 1'b0);
    chk("zero_cc", 64'(cc), 64'(exp_cc(3'b100)));
    bus.req_valid = 2'b10;
    set1(64'd3, 64'd4, 2'b00);
    step();
    chk_rsp("r1add", 1'b1, 1'b1, 64'd7, 1'b0);
    chk("r1add_cc", 64'(cc), 64'(exp_cc(3'b100)));
    bus.req_valid = 2'b00;
    step();
    chk("pre_stall_empty", 64'(bus.rsp_valid), 64'd0);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    set0(64'd10, 64'd3, 2'b01);
    set1(64'd1, 64'd2, 2'b00);
    #1;
    chk("stall_first_ready", 64'(bus.req_ready), 64'd1);
    step();
    chk_rsp("stall0", 1'b1, 1'b0, 64'd7, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      step();
      chk_rsp("stall_hold", 1'b1, 1'b0, 64'd7, 1'b0);
    end
    chk("stall_ready_end", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("popgnt_ready", 64'(bus.req_ready), 64'd2);
    step();
    chk_rsp("popgnt", 1'b1, 1'b1, 64'd3, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    step();
    chk_rsp("midrst", 1'b0, 1'b0, 64'd0, 1'b0);
    chk("midrst_cc", 64'(cc), 64'(3'b100));
    rst = 1'b0;
    #1;
    chk("midrst_ptr", 64'(bus.req_ready), 64'd1);
    step();
    chk_rsp("post_rst", 1'b1, 1'b0, 64'd7, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
